// File: rtl/can_pkg.sv
// rtl/can_pkg.sv - shared CAN bit-stuffing types and constants
package can_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DATA  = 2'd1,
    ST_STUFF = 2'd2,
    ST_TAIL  = 2'd3
  } can_state_e;

  localparam logic CAN_RECESSIVE            = 1'b1;
  localparam logic CAN_DOMINANT             = 1'b0;
  localparam int   CAN_STUFF_CONSEC_DEFAULT = 5;

endpackage

// File: rtl/can_stuff_tx_if.sv
// rtl/can_stuff_tx_if.sv - word input, baud strobe and serial output bundle of the stuffer
interface can_stuff_tx_if #(
  parameter int WIDTH = 8
);

  logic             bit_en;
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             din_last;
  logic             stuff_en;
  logic             txout;
  logic             stuff_out;
  logic             busy;
  logic             err;

  // Word source and baud generator side
  modport master (
    output bit_en, din, din_valid, din_last, stuff_en,
    input  din_ready, txout, stuff_out, busy, err
  );

  // Stuffer side
  modport slave (
    input  bit_en, din, din_valid, din_last, stuff_en,
    output din_ready, txout, stuff_out, busy, err
  );

endinterface

// File: rtl/can_run_counter.sv
// rtl/can_run_counter.sv - run-length tracker of identical bits, shared by stuffer and unstuffer
module can_run_counter
  import can_pkg::*;
#(
  parameter int  CONSEC = CAN_STUFF_CONSEC_DEFAULT,
  localparam int RW     = $clog2(CONSEC + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          bit_i,
  input  logic          strobe_i,
  input  logic          clear_i,
  input  logic          enable_i,
  output logic [RW-1:0] run_o,
  output logic          stuff_due_o
);

  localparam logic [RW-1:0] CONSEC_W = RW'(CONSEC);
  localparam logic [RW-1:0] RUN_ONE  = RW'(1);
  localparam logic [RW-1:0] RUN_MAX  = '1;

  logic [RW-1:0] run_q, run_d;
  logic          last_q, last_d;

  // Next run length: extend on a repeated bit, restart at 1 otherwise or when stuffing is off
  always_comb begin
    run_d  = run_q;
    last_d = last_q;
    if (strobe_i) begin
      last_d = bit_i;
      if (!enable_i) begin
        run_d = RUN_ONE;
      end else if (bit_i == last_q && run_q != '0) begin
        run_d = (run_q == RUN_MAX) ? run_q : run_q + 1'b1;
      end else begin
        run_d = RUN_ONE;
      end
    end
  end

  // Flags that the bit being strobed completes a run, so the next bit must be a stuff bit
  assign stuff_due_o = enable_i && strobe_i && (run_d == CONSEC_W);
  assign run_o       = run_q;

  // Run state; cleared between frames so the first bit always starts a fresh run
  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      run_q  <= '0;
      last_q <= CAN_RECESSIVE;
    end else begin
      run_q  <= run_d;
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/can_stuff_tx.sv
// rtl/can_stuff_tx.sv - CAN transmit bit stuffer: parallel words in, stuffed serial stream out
module can_stuff_tx
  import can_pkg::*;
#(
  parameter int CONSEC = CAN_STUFF_CONSEC_DEFAULT,
  parameter int WIDTH  = 8
) (
  input  logic          clk,
  input  logic          rst,
  can_stuff_tx_if.slave bus
);

  localparam int             CW       = $clog2(WIDTH + 1);
  localparam int             RW       = $clog2(CONSEC + 1);
  localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);
  localparam logic [RW-1:0]  CONSEC_W = RW'(CONSEC);

  can_state_e       state_q;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] hold_q;
  logic             sh_full_q;
  logic             sh_last_q;
  logic             hold_full_q;
  logic             hold_last_q;
  logic [CW-1:0]    bit_cnt_q;
  logic             txout_q;
  logic             stuff_out_q;
  logic             err_q;

  logic             accept;
  logic             word_end;
  logic             take_hold;
  logic             tail_pending;
  logic             rc_strobe;
  logic             rc_bit;
  logic             rc_clear;
  logic             stuff_due;
  logic [RW-1:0]    run;

  assign accept       = bus.din_valid && !hold_full_q;
  assign word_end     = sh_full_q && (bit_cnt_q == LAST_BIT);
  // In TAIL the run still sits at CONSEC until the trailing stuff bit has gone out
  assign tail_pending = (run == CONSEC_W);
  assign rc_clear     = (state_q == ST_IDLE);

  // Decide when the holding word moves to the shifter and which bit feeds the run tracker
  always_comb begin
    take_hold = 1'b0;
    rc_strobe = 1'b0;
    rc_bit    = ~txout_q;
    case (state_q)
      ST_IDLE: begin
        take_hold = hold_full_q;
      end
      ST_DATA: begin
        rc_bit    = shift_q[WIDTH-1];
        rc_strobe = bus.bit_en && sh_full_q;
        take_hold = bus.bit_en && word_end && !sh_last_q && hold_full_q;
      end
      ST_STUFF: begin
        rc_strobe = bus.bit_en;
      end
      ST_TAIL: begin
        rc_strobe = bus.bit_en && tail_pending;
      end
      default: ;
    endcase
  end

  can_run_counter #(
    .CONSEC (CONSEC)
  ) u_run (
    .clk         (clk),
    .rst         (rst),
    .bit_i       (rc_bit),
    .strobe_i    (rc_strobe),
    .clear_i     (rc_clear),
    .enable_i    (bus.stuff_en),
    .run_o       (run),
    .stuff_due_o (stuff_due)
  );

  // Frame sequencer: word buffering, bit emission, stuff insertion and frame termination
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      hold_q      <= '0;
      sh_full_q   <= 1'b0;
      sh_last_q   <= 1'b0;
      hold_full_q <= 1'b0;
      hold_last_q <= 1'b0;
      bit_cnt_q   <= '0;
      txout_q     <= CAN_RECESSIVE;
      stuff_out_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      err_q       <= 1'b0;
      hold_full_q <= (hold_full_q && !take_hold) || accept;
      if (accept) begin
        hold_q      <= bus.din;
        hold_last_q <= bus.din_last;
      end
      case (state_q)
        ST_IDLE: begin
          txout_q     <= CAN_RECESSIVE;
          stuff_out_q <= 1'b0;
          if (take_hold) begin
            shift_q   <= hold_q;
            sh_last_q <= hold_last_q;
            sh_full_q <= 1'b1;
            bit_cnt_q <= '0;
            state_q   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (bus.bit_en) begin
            if (sh_full_q) begin
              txout_q     <= shift_q[WIDTH-1];
              stuff_out_q <= 1'b0;
              shift_q     <= shift_q << 1;
              bit_cnt_q   <= bit_cnt_q + 1'b1;
              if (word_end) begin
                if (take_hold) begin
                  shift_q   <= hold_q;
                  sh_last_q <= hold_last_q;
                  bit_cnt_q <= '0;
                  state_q   <= stuff_due ? ST_STUFF : ST_DATA;
                end else begin
                  // Final bit keeps its full bit period; the frame closes on the next strobe
                  sh_full_q <= 1'b0;
                  if (sh_last_q && stuff_due) begin
                    state_q <= ST_TAIL;
                  end
                end
              end else if (stuff_due) begin
                state_q <= ST_STUFF;
              end
            end else begin
              // End of the last bit period: clean end of frame, or underrun when no last flag
              txout_q     <= CAN_RECESSIVE;
              stuff_out_q <= 1'b0;
              err_q       <= !sh_last_q;
              state_q     <= ST_IDLE;
            end
          end
        end
        ST_STUFF: begin
          if (bus.bit_en) begin
            txout_q     <= ~txout_q;
            stuff_out_q <= 1'b1;
            state_q     <= ST_DATA;
          end
        end
        ST_TAIL: begin
          if (bus.bit_en) begin
            if (tail_pending) begin
              txout_q     <= ~txout_q;
              stuff_out_q <= 1'b1;
            end else begin
              txout_q     <= CAN_RECESSIVE;
              stuff_out_q <= 1'b0;
              state_q     <= ST_IDLE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.din_ready = !hold_full_q;
  assign bus.txout     = txout_q;
  assign bus.stuff_out = stuff_out_q;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.err       = err_q;

endmodule

// File: tb/tb_can_stuff_tx.sv
// tb/tb_can_stuff_tx.sv - self-checking bench for can_stuff_tx
module tb_can_stuff_tx;

  localparam int CONSEC = 5;
  localparam int WIDTH  = 8;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  can_stuff_tx_if #(.WIDTH(WIDTH)) bus ();

  can_stuff_tx #(
    .CONSEC (CONSEC),
    .WIDTH  (WIDTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int         checks = 0;
  int         errors = 0;
  logic [7:0] words[$];
  logic [1:0] obs[$];
  logic [1:0] exp_q[$];
  int         err_cycles;
  int         exp_err;
  logic       ended;
  logic       end_tx;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: output stream rule -- after CONSEC equal bits (stuff bits included) insert the complement
  task automatic build_model(input logic fin_last, input logic se, output int e_err);
    int   run;
    logic prev;
    logic b;
    run  = 0;
    prev = 1'b1;
    exp_q.delete();
    for (int w = 0; w < words.size(); w++) begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        b = words[w][i];
        exp_q.push_back({1'b0, b});
        run  = (run != 0 && b == prev) ? run + 1 : 1;
        prev = b;
        if (se && run == CONSEC && !(w == words.size() - 1 && i == 0 && !fin_last)) begin
          exp_q.push_back({1'b1, ~b});
          prev = ~b;
          run  = 1;
        end
      end
    end
    e_err = fin_last ? 0 : 1;
  endtask

  task automatic run_frame(input logic fin_last, input logic se, input int per, input int abort_after);
    int   idx;
    int   phase;
    int   cyc;
    logic ben;
    logic busy_pre;
    logic acc;
    idx = 0; phase = 0; cyc = 0;
    obs.delete();
    err_cycles   = 0;
    ended        = 1'b0;
    end_tx       = 1'b0;
    bus.stuff_en = se;
    while (!ended && cyc < 3000) begin
      bus.din_valid = (idx < words.size());
      bus.din       = (idx < words.size()) ? words[idx] : 8'h00;
      bus.din_last  = (idx == words.size() - 1) ? fin_last : 1'b0;
      ben           = (phase == per - 1);
      bus.bit_en    = ben;
      phase         = (phase + 1) % per;
      busy_pre      = bus.busy;
      acc           = bus.din_valid && bus.din_ready;
      @(posedge clk); #1;
      cyc++;
      if (acc) idx++;
      if (bus.err) err_cycles++;
      if (ben && busy_pre) begin
        if (bus.busy) obs.push_back({bus.stuff_out, bus.txout});
        else begin
          ended  = 1'b1;
          end_tx = bus.txout;
        end
      end
      if (abort_after > 0 && obs.size() == abort_after && !ended) begin
        rst = 1'b1; bus.bit_en = 1'b0; bus.din_valid = 1'b0;
        @(posedge clk); #1;
        check("rst_txout", bus.txout, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_ready", bus.din_ready, 1);
        check("rst_stuff_out", bus.stuff_out, 0);
        check("rst_err", bus.err, 0);
        rst   = 1'b0;
        ended = 1'b1;
      end
    end
    bus.bit_en = 1'b0; bus.din_valid = 1'b0; bus.din_last = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (bus.err) err_cycles++;
    end
    if (!ended) begin
      check("frame_timeout", ended, 1);
      rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    end
  endtask

  task automatic compare_frame(input string tag, input int e_err);
    check({tag, "_len"}, obs.size(), exp_q.size());
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++)
      check($sformatf("%s_bit%0d", tag, i), obs[i], exp_q[i]);
    check({tag, "_err_cycles"}, err_cycles, e_err);
    check({tag, "_end_txout"}, end_tx, 1);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_ready"}, bus.din_ready, 1);
    check({tag, "_stuff_out"}, bus.stuff_out, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.bit_en = 1'b0; bus.din = '0; bus.din_valid = 1'b0; bus.din_last = 1'b0; bus.stuff_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_txout", bus.txout, 1);
    check("reset_busy", bus.busy, 0);
    check("reset_ready", bus.din_ready, 1);
    check("reset_stuff_out", bus.stuff_out, 0);
    check("reset_err", bus.err, 0);
    rst = 1'b0;

    repeat (3) begin
      bus.bit_en = 1'b1;
      @(posedge clk); #1;
      bus.bit_en = 1'b0;
      check("idle_bit_en_txout", bus.txout, 1);
      check("idle_bit_en_busy", bus.busy, 0);
    end

    words = '{8'h00};
    run_frame(1'b1, 1'b1, 4, 0);
    exp_q = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd3, 2'd0, 2'd0, 2'd0};
    compare_frame("f00", 0);

    words = '{8'h0F, 8'h80};
    run_frame(1'b1, 1'b1, 4, 0);
    exp_q = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2,
              2'd0, 2'd0, 2'd0, 2'd0, 2'd3, 2'd0, 2'd0, 2'd0};
    compare_frame("f0f80", 0);

    words = '{8'h1F};
    run_frame(1'b1, 1'b1, 4, 0);
    exp_q = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2};
    compare_frame("f1f_tail", 0);

    words = '{8'hA5};
    run_frame(1'b0, 1'b1, 4, 0);
    exp_q = '{2'd1, 2'd0, 2'd1, 2'd0, 2'd0, 2'd1, 2'd0, 2'd1};
    compare_frame("fa5_underrun", 1);

    words = '{8'h00};
    run_frame(1'b1, 1'b0, 4, 0);
    exp_q = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
    compare_frame("f00_nostuff", 0);

    words = '{8'hFF};
    run_frame(1'b1, 1'b1, 4, 3);
    check("abort_len", obs.size(), 3);
    for (int i = 0; i < obs.size() && i < 3; i++)
      check($sformatf("abort_bit%0d", i), obs[i], 2'd1);
    words = '{8'h00};
    run_frame(1'b1, 1'b1, 4, 0);
    exp_q = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd3, 2'd0, 2'd0, 2'd0};
    compare_frame("f00_after_rst", 0);

    for (int f = 0; f < 40; f++) begin
      logic se;
      logic fl;
      int   n;
      int   per;
      words.delete();
      n   = $urandom_range(1, 4);
      se  = ($urandom_range(0, 3) != 0);
      fl  = ($urandom_range(0, 4) != 0);
      per = $urandom_range(1, 4);
      for (int k = 0; k < n; k++) begin
        case ($urandom_range(0, 3))
          0:       words.push_back(8'h00);
          1:       words.push_back(8'hFF);
          2:       words.push_back(($urandom_range(0, 1) != 0) ? 8'h0F : 8'hF0);
          default: words.push_back(8'($urandom));
        endcase
      end
      build_model(fl, se, exp_err);
      run_frame(fl, se, per, 0);
      compare_frame($sformatf("rnd%0d", f), exp_err);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
